// File: rtl/seg_scroller_pkg.sv
// Shared definitions for the seven-segment message scroller: character codes
// and the controller state encoding.
package seg_scroller_pkg;

  localparam logic [4:0] CharA     = 5'd10;
  localparam logic [4:0] CharB     = 5'd11;
  localparam logic [4:0] CharC     = 5'd12;
  localparam logic [4:0] CharD     = 5'd13;
  localparam logic [4:0] CharE     = 5'd14;
  localparam logic [4:0] CharF     = 5'd15;
  localparam logic [4:0] CharH     = 5'd16;
  localparam logic [4:0] CharL     = 5'd17;
  localparam logic [4:0] CharO     = 5'd18;
  localparam logic [4:0] CharP     = 5'd19;
  localparam logic [4:0] CharU     = 5'd20;
  localparam logic [4:0] CharBlank = 5'd31;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StScroll,
    StHold
  } state_e;

endpackage

// File: rtl/seg7_char_decode.sv
// Combinational character-code to seven-segment decoder; output is active-low,
// bit 0 = segment a through bit 6 = segment g.
module seg7_char_decode
  import seg_scroller_pkg::*;
(
  input  logic [4:0] char_code,
  output logic [6:0] seg
);

  logic [6:0] seg_on;  // active-high pattern, gfedcba

  always_comb begin
    seg_on = 7'h00;
    case (char_code)
      5'd0:      seg_on = 7'h3f;
      5'd1:      seg_on = 7'h06;
      5'd2:      seg_on = 7'h5b;
      5'd3:      seg_on = 7'h4f;
      5'd4:      seg_on = 7'h66;
      5'd5:      seg_on = 7'h6d;
      5'd6:      seg_on = 7'h7d;
      5'd7:      seg_on = 7'h07;
      5'd8:      seg_on = 7'h7f;
      5'd9:      seg_on = 7'h6f;
      CharA:     seg_on = 7'h77;
      CharB:     seg_on = 7'h7c;
      CharC:     seg_on = 7'h39;
      CharD:     seg_on = 7'h5e;
      CharE:     seg_on = 7'h79;
      CharF:     seg_on = 7'h71;
      CharH:     seg_on = 7'h76;
      CharL:     seg_on = 7'h38;
      CharO:     seg_on = 7'h3f;
      CharP:     seg_on = 7'h73;
      CharU:     seg_on = 7'h3e;
      CharBlank: seg_on = 7'h00;
      default:   seg_on = 7'h00;
    endcase
  end

  assign seg = ~seg_on;

endmodule

// File: rtl/seg_scroller.sv
// Scrolling message display: buffers a short character message and slides a
// NUM_DIGITS-wide window across it at a programmable rate.
module seg_scroller
  import seg_scroller_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned MSG_DEPTH  = 16,
  parameter int unsigned TICK_DIV   = 50_000_000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_valid,
  input  logic [4:0]              wr_char,
  input  logic                    wr_last,
  output logic                    wr_ready,
  input  logic                    enable,
  input  logic                    dir,
  input  logic [1:0]              speed,
  input  logic                    stop,
  output logic [7*NUM_DIGITS-1:0] hex,
  output logic                    busy,
  output logic                    wrap
);

  localparam int unsigned PtrW = $clog2(MSG_DEPTH);
  localparam int unsigned LenW = PtrW + 1;
  localparam int unsigned PreW = $clog2(TICK_DIV);
  localparam int unsigned IdxW = LenW + 5;
  localparam logic [LenW-1:0] LenMax  = LenW'(MSG_DEPTH);
  localparam logic [PreW-1:0] PreLast = PreW'(TICK_DIV - 1);

  state_e          state;
  logic [LenW-1:0] len;
  logic [PtrW-1:0] ptr;
  logic [PreW-1:0] presc;
  logic [1:0]      step_cnt;
  logic [4:0]      msg [MSG_DEPTH];

  logic            wr_en;
  logic            tick;
  logic [PtrW-1:0] ptr_max;
  logic [PtrW-1:0] ptr_fwd;
  logic [PtrW-1:0] ptr_bwd;
  logic            wrap_now;
  logic [7*NUM_DIGITS-1:0] hex_next;

  assign wr_ready = (state == StIdle) || (state == StLoad);
  assign busy     = (state != StIdle);
  assign wr_en    = wr_valid && wr_ready && !stop;
  assign tick     = (presc == PreLast);

  always_comb begin
    ptr_max  = PtrW'(len - LenW'(1));
    ptr_fwd  = (ptr == ptr_max) ? '0 : ptr + PtrW'(1);
    ptr_bwd  = (ptr == '0) ? ptr_max : ptr - PtrW'(1);
    wrap_now = dir ? (ptr == '0) : (ptr == ptr_max);
  end

  // Buffer is only ever read behind a valid length, so it carries no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      msg[(state == StIdle) ? '0 : len[PtrW-1:0]] <= wr_char;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= StIdle;
      len      <= '0;
      ptr      <= '0;
      presc    <= '0;
      step_cnt <= '0;
      wrap     <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (stop) begin
        state    <= StIdle;
        len      <= '0;
        ptr      <= '0;
        presc    <= '0;
        step_cnt <= '0;
      end else begin
        case (state)
          StIdle: begin
            if (wr_en) begin
              len      <= LenW'(1);
              ptr      <= '0;
              presc    <= '0;
              step_cnt <= '0;
              state    <= wr_last ? StScroll : StLoad;
            end
          end
          StLoad: begin
            if (wr_en) begin
              len <= len + LenW'(1);
              if (wr_last || (len + LenW'(1) == LenMax)) begin
                ptr      <= '0;
                presc    <= '0;
                step_cnt <= '0;
                state    <= StScroll;
              end
            end
          end
          StScroll: begin
            // The cycle that sees enable low still counts; HOLD freezes from then on.
            if (!enable) state <= StHold;
            presc <= tick ? '0 : presc + PreW'(1);
            if (step_cnt > speed) begin
              step_cnt <= '0;
            end else if (tick) begin
              if (step_cnt == speed) begin
                step_cnt <= '0;
                ptr      <= dir ? ptr_bwd : ptr_fwd;
                wrap     <= wrap_now;
              end else begin
                step_cnt <= step_cnt + 2'd1;
              end
            end
          end
          StHold: begin
            if (enable) state <= StScroll;
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

  // Message index for a window position, reduced modulo the message length.
  function automatic logic [PtrW-1:0] win_index(input logic [PtrW-1:0] base,
                                                 input int unsigned     off,
                                                 input logic [LenW-1:0] n);
    logic [IdxW-1:0] v;
    v = IdxW'(base) + IdxW'(off);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v >= IdxW'(n)) v = v - IdxW'(n);
    end
    return v[PtrW-1:0];
  endfunction

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    logic [PtrW-1:0] idx;
    logic [6:0]      seg;

    assign idx = win_index(ptr, NUM_DIGITS - 1 - k, len);

    seg7_char_decode u_decode (
      .char_code (msg[idx]),
      .seg       (seg)
    );

    assign hex_next[7*k +: 7] = seg;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hex <= '1;
    end else if (stop || state == StIdle || state == StLoad) begin
      hex <= '1;
    end else begin
      hex <= hex_next;
    end
  end

endmodule

// File: tb/tb_seg_scroller.sv
// Scoreboard bench for seg_scroller: predicted display/wrap events are queued
// with their cycle stamps and a negedge monitor matches them against the DUT.
module tb_seg_scroller;

  localparam int ND = 8;
  localparam int MD = 16;
  localparam int TD = 4;
  localparam logic [55:0] Blank = '1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wr_valid = 1'b0;
  logic [4:0]  wr_char = '0;
  logic        wr_last = 1'b0;
  logic        enable = 1'b1;
  logic        dir = 1'b0;
  logic [1:0]  speed = '0;
  logic        stop = 1'b0;
  logic        wr_ready;
  logic        busy;
  logic        wrap;
  logic [55:0] hex;

  seg_scroller #(
    .NUM_DIGITS (ND),
    .MSG_DEPTH  (MD),
    .TICK_DIV   (TD)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_valid (wr_valid),
    .wr_char  (wr_char),
    .wr_last  (wr_last),
    .wr_ready (wr_ready),
    .enable   (enable),
    .dir      (dir),
    .speed    (speed),
    .stop     (stop),
    .hex      (hex),
    .busy     (busy),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned at;
    logic [55:0] hex;
    logic        wrap;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  bit          mon_on = 1'b0;
  logic [55:0] last_hex = '1;
  logic [4:0]  mdl_msg[$];
  int unsigned e_cyc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Segment pattern from the lit segment letters, active-low.
  function automatic logic [6:0] mdl_seg(input logic [4:0] c);
    string s;
    logic [6:0] r;
    int b;
    r = '1;
    case (c)
      5'd0:  s = "abcdef";
      5'd1:  s = "bc";
      5'd2:  s = "abdeg";
      5'd3:  s = "abcdg";
      5'd4:  s = "bcfg";
      5'd5:  s = "acdfg";
      5'd6:  s = "acdefg";
      5'd7:  s = "abc";
      5'd8:  s = "abcdefg";
      5'd9:  s = "abcdfg";
      5'd10: s = "abcefg";
      5'd11: s = "cdefg";
      5'd12: s = "adef";
      5'd13: s = "bcdeg";
      5'd14: s = "adefg";
      5'd15: s = "aefg";
      5'd16: s = "bcefg";
      5'd17: s = "def";
      5'd18: s = "abcdef";
      5'd19: s = "abefg";
      5'd20: s = "bcdef";
      default: s = "";
    endcase
    for (int i = 0; i < s.len(); i++) begin
      b = int'(s[i]) - 97;
      r[3'(b)] = 1'b0;
    end
    return r;
  endfunction

  // Window at offset p: digit k shows msg[(p + ND-1-k) mod L].
  function automatic logic [55:0] frame(input int p);
    logic [55:0] f;
    int L;
    L = mdl_msg.size();
    f = '0;
    for (int k = 0; k < ND; k++) f = {mdl_seg(mdl_msg[(p + ND - 1 - k) % L]), f[55:7]};
    return f;
  endfunction

  task automatic expect_at(input int unsigned at, input logic [55:0] h, input logic w);
    exp_t e;
    e.at = at;
    e.hex = h;
    e.wrap = w;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_on) begin
      while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
        chk("missed_event_cycle", 64'(cyc), 64'(exp_q[0].at));
        void'(exp_q.pop_front());
      end
      if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
        e = exp_q.pop_front();
        chk("hex_frame", 64'(hex), 64'(e.hex));
        chk("wrap_pulse", 64'(wrap), 64'(e.wrap));
        last_hex = e.hex;
      end else begin
        chk("hex_steady", 64'(hex), 64'(last_hex));
        chk("wrap_quiet", 64'(wrap), 64'(1'b0));
      end
    end
  end

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int unsigned c);
    while (cyc < c) step_clk();
  endtask

  task automatic load_msg(input bit mark_last);
    for (int i = 0; i < mdl_msg.size(); i++) begin
      wr_valid = 1'b1;
      wr_char  = mdl_msg[i];
      wr_last  = mark_last && (i == mdl_msg.size() - 1);
      step_clk();
    end
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    e_cyc    = cyc;
  endtask

  task automatic set_hello();
    mdl_msg = '{5'd16, 5'd14, 5'd17, 5'd17, 5'd18};
  endtask

  // Queue the display/wrap events for nsteps steps; steps after hold_after are
  // delayed by hold_len cycles; stop_step (if nonzero) is aborted by stop.
  task automatic predict(input int unsigned spd, input bit d, input int unsigned nsteps,
                         input int unsigned hold_after, input int unsigned hold_len,
                         input int unsigned stop_step, output int unsigned last_at);
    int unsigned per;
    int unsigned s;
    int L, p, np;
    bit w;
    per = (spd + 1) * TD;
    L = mdl_msg.size();
    p = 0;
    expect_at(e_cyc + 1, frame(0), 1'b0);
    last_at = e_cyc + 1;
    for (int unsigned k = 1; k <= nsteps; k++) begin
      s = e_cyc + k * per + ((k > hold_after) ? hold_len : 0);
      if (k == stop_step) begin
        expect_at(s, Blank, 1'b0);
        last_at = s;
        return;
      end
      np = d ? (p + L - 1) % L : (p + 1) % L;
      w  = d ? (p == 0) : (np == 0);
      expect_at(s, frame(p), w);
      expect_at(s + 1, frame(np), 1'b0);
      p = np;
      last_at = s + 1;
    end
  endtask

  task automatic finish_msg(input int unsigned last_at);
    wait_until(last_at);
    expect_at(cyc + 1, Blank, 1'b0);
    stop = 1'b1;
    step_clk();
    stop = 1'b0;
    chk("busy_after_stop", 64'(busy), 64'(1'b0));
    chk("ready_after_stop", 64'(wr_ready), 64'(1'b1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int unsigned last;
    int unsigned L, spd, r;
    bit d;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_hex", 64'(hex), 64'(Blank));
    chk("reset_busy", 64'(busy), 64'(1'b0));
    chk("reset_wrap", 64'(wrap), 64'(1'b0));
    reset = 1'b1;
    step_clk();
    chk("idle_ready", 64'(wr_ready), 64'(1'b1));
    chk("idle_busy", 64'(busy), 64'(1'b0));
    mon_on = 1'b1;

    // HELLO scrolling left at full rate.
    set_hello();
    speed = 2'd0;
    dir = 1'b0;
    load_msg(1'b1);
    chk("hello_busy", 64'(busy), 64'(1'b1));
    chk("hello_ready", 64'(wr_ready), 64'(1'b0));
    predict(0, 1'b0, 6, 6, 0, 0, last);
    finish_msg(last);

    // HELLO scrolling right.
    dir = 1'b1;
    load_msg(1'b1);
    predict(0, 1'b1, 3, 3, 0, 0, last);
    finish_msg(last);

    // Slowest rate with a 10-cycle freeze partway through the second step.
    speed = 2'd3;
    dir = 1'b0;
    load_msg(1'b1);
    predict(3, 1'b0, 4, 1, 10, 0, last);
    wait_until(e_cyc + 20);
    enable = 1'b0;
    wait_until(e_cyc + 30);
    enable = 1'b1;
    finish_msg(last);

    // Full buffer without wr_last; a further offer must be refused.
    speed = 2'd0;
    mdl_msg.delete();
    for (int i = 0; i < MD; i++) mdl_msg.push_back(5'($urandom_range(0, 20)));
    load_msg(1'b0);
    chk("full_ready", 64'(wr_ready), 64'(1'b0));
    chk("full_busy", 64'(busy), 64'(1'b1));
    wr_valid = 1'b1;
    wr_char = 5'd8;
    predict(0, 1'b0, 17, 17, 0, 0, last);
    wait_until(last);
    chk("full_ready_late", 64'(wr_ready), 64'(1'b0));
    wr_valid = 1'b0;
    finish_msg(last);

    // stop on the same edge as a wrapping step.
    set_hello();
    load_msg(1'b1);
    predict(0, 1'b0, 5, 5, 0, 5, last);
    wait_until(last - 1);
    stop = 1'b1;
    step_clk();
    stop = 1'b0;
    chk("stop_step_busy", 64'(busy), 64'(1'b0));
    step_clk();

    // Random messages, rates and directions; the first has length 1.
    for (int it = 0; it < 6; it++) begin
      L = (it == 0) ? 1 : $urandom_range(1, MD);
      mdl_msg.delete();
      for (int unsigned i = 0; i < L; i++) begin
        r = $urandom_range(0, 23);
        if (r <= 20) mdl_msg.push_back(5'(r));
        else if (r == 21) mdl_msg.push_back(5'd31);
        else mdl_msg.push_back(5'($urandom_range(21, 30)));
      end
      spd = $urandom_range(0, 3);
      d = 1'($urandom_range(0, 1));
      speed = 2'(spd);
      dir = d;
      load_msg((L < MD) || ($urandom_range(0, 1) == 1));
      predict(spd, d, L + 1, L + 1, 0, 0, last);
      finish_msg(last);
    end

    // Asynchronous reset in the middle of a scroll.
    set_hello();
    speed = 2'd0;
    dir = 1'b0;
    load_msg(1'b1);
    predict(0, 1'b0, 2, 2, 0, 0, last);
    wait_until(last + 1);
    mon_on = 1'b0;
    chk("pre_reset_busy", 64'(busy), 64'(1'b1));
    #2;
    reset = 1'b0;
    #1;
    chk("async_hex", 64'(hex), 64'(Blank));
    chk("async_busy", 64'(busy), 64'(1'b0));
    chk("async_wrap", 64'(wrap), 64'(1'b0));
    exp_q.delete();
    last_hex = Blank;
    step_clk();
    reset = 1'b1;
    step_clk();
    chk("post_reset_ready", 64'(wr_ready), 64'(1'b1));
    chk("post_reset_hex", 64'(hex), 64'(Blank));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_scroller.md
SEG_SCROLLER -- requirements
Module: seg_scroller

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8: number of seven-segment digits driven (range 2..16).
REQ-002 SHALL have parameter MSG_DEPTH, default 16: maximum message length in characters (power of two, range 4..64).
REQ-003 SHALL have parameter TICK_DIV, default 50_000_000: clk cycles per base scroll tick (>=2).
REQ-004 SHALL have port clk  input  1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port wr_valid  input  1: character offered on wr_char.
REQ-007 SHALL have port wr_char  input  5: character code (0-9 digits, 10-15 A-F, 16 H, 17 L, 18 O, 19 P, 20 U, 31 blank; others blank).
REQ-008 SHALL have port wr_last  input  1: qualifies the final character of a message.
REQ-009 SHALL have port wr_ready  output  1: block accepts wr_char this cycle.
REQ-010 SHALL have port enable  input  1: 1 scroll runs; 0 scroll frozen.
REQ-011 SHALL have port dir  input  1: 0 text moves left, 1 text moves right.
REQ-012 SHALL have port speed  input  2: steps occur every (speed+1) base ticks.
REQ-013 SHALL have port stop  input  1: abort message, blank display, return to idle.
REQ-014 SHALL have port hex  output  7*NUM_DIGITS: digit k at bits [7k+6:7k], segments active-low, bit 0=a .. bit 6=g; digit 0 rightmost.
REQ-015 SHALL have port busy  output  1: high when state is not IDLE.
REQ-016 SHALL have port wrap  output  1: one-cycle pulse when the window offset wraps.

Function
REQ-017 SHALL implement states IDLE, LOAD, SCROLL, HOLD.
REQ-018 A write SHALL be accepted only when wr_valid and wr_ready are both 1 on a clock edge.
REQ-019 wr_ready SHALL be 1 in IDLE and LOAD, 0 in SCROLL and HOLD.
REQ-020 An accepted write in IDLE SHALL store the character at index 0, set length to 1, and enter LOAD (or SCROLL if wr_last=1).
REQ-021 An accepted write in LOAD SHALL store at index length and increment length; wr_last=1 or length reaching MSG_DEPTH SHALL enter SCROLL.
REQ-022 Entry to SCROLL SHALL set offset ptr=0 and clear prescaler and step counter.
REQ-023 In SCROLL/HOLD, digit k SHALL show msg[(ptr + NUM_DIGITS-1-k) mod length]; messages shorter than NUM_DIGITS repeat.
REQ-024 In IDLE and LOAD all digits SHALL be blank (all segment bits 1).
REQ-025 Prescaler SHALL count 0..TICK_DIV-1 in SCROLL only; terminal count is a base tick; the step counter counts base ticks 0..speed and a step occurs on its terminal tick.
REQ-026 A step with dir=0 SHALL set ptr=(ptr+1) mod length; dir=1 SHALL set ptr=(ptr-1) mod length.
REQ-027 wrap SHALL pulse for exactly the cycle following a step where ptr goes L-1->0 (dir=0) or 0->L-1 (dir=1).
REQ-028 length=1 SHALL keep ptr=0 and pulse wrap on every step.
REQ-029 speed or dir changes SHALL take effect at the next step; the step counter SHALL restart at 0 if it exceeds a new smaller speed.
REQ-030 SCROLL with enable=0 SHALL enter HOLD; HOLD with enable=1 SHALL return to SCROLL; prescaler, step counter and ptr SHALL be held in HOLD.
REQ-031 stop=1 SHALL enter IDLE next cycle from any state, clear length and ptr, and take priority over writes and steps.
REQ-032 Display update SHALL have one-cycle latency from ptr change to hex change (registered output).

Reset
REQ-033 reset low SHALL asynchronously force IDLE, length=0, ptr=0, prescaler and step counter 0, wr_ready=1 (after release), busy=0, wrap=0, hex all 1s.
REQ-034 Message buffer contents SHALL not require reset.

Structure
REQ-035 A shared package SHALL hold the 5-bit character codes, the blank code, and the state enumeration.
REQ-036 Character-to-segment decoding SHALL be a combinational sub-module seg7_char_decode, instantiated once per digit.

Verification (NUM_DIGITS=8, MSG_DEPTH=16, TICK_DIV=4)
REQ-037 Load H,E,L,L,O (last on O), speed=0, dir=0 -> busy=1; digits 7..0 show H E L L O H E L, after 4 cycles E L L O H E L L; wrap pulses after the 5th step.
REQ-038 Same message, dir=1 -> first step shows O H E L L O H E with wrap pulse.
REQ-039 speed=3 -> steps every 16 cycles; enable low for 10 cycles mid-count -> next step delayed exactly 10 cycles.
REQ-040 Write 16 chars with wr_last=0 -> SCROLL entered after the 16th, wr_ready=0; a 17th wr_valid not accepted.
REQ-041 stop asserted simultaneously with a step -> IDLE, no wrap, hex all 1s next cycle.
REQ-042 reset low mid-SCROLL, asynchronous to clk -> hex all 1s and busy=0 immediately, before the next clk edge.
